// File: rtl/blake2b_round_ctrl_pkg.sv
// Shared types and constants for the BLAKE2b compression sequencer.
package blake2b_round_ctrl_pkg;

    localparam int unsigned BLAKE2B_ROUNDS = 12;

    typedef logic [3:0] sigma_index_t;
    typedef logic [3:0] round_t;
    typedef logic [2:0] g_idx_t;

    typedef enum logic [2:0] {
        CtrlIdle  = 3'd0,
        CtrlInit  = 3'd1,
        CtrlIssue = 3'd2,
        CtrlWait  = 3'd3,
        CtrlFinal = 3'd4,
        CtrlDone  = 3'd5
    } ctrl_state_e;

    // G step i consumes message words sigma[r][2i] and sigma[r][2i+1].
    function automatic sigma_index_t sigma_col(input g_idx_t g, input logic second);
        return {g, second};
    endfunction

endpackage

// File: rtl/blake2b_round_ctrl.sv
// BLAKE2b compression sequencer: init, ROUNDS x 8 G steps handshaked with a shared
// G unit, then finalize. All outputs come from registers.
module blake2b_round_ctrl
    import blake2b_round_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS      = BLAKE2B_ROUNDS,
    parameter int unsigned G_PER_ROUND = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       final_block,
    output logic       busy,
    output logic       init_v,
    output logic       inv_v14,
    output logic       g_start,
    input  logic       g_done,
    output logic [3:0] round,
    output logic [2:0] g_idx,
    output logic [3:0] sigma_col_x,
    output logic [3:0] sigma_col_y,
    output logic       fin_xor,
    output logic       done
);

    localparam round_t LastRound = round_t'(ROUNDS - 1);
    localparam g_idx_t LastG     = g_idx_t'(G_PER_ROUND - 1);

    ctrl_state_e state_q, state_d;
    round_t      round_q, round_d;
    g_idx_t      g_idx_q, g_idx_d;
    logic        flag_q, flag_d;
    logic        busy_q, busy_d;
    logic        init_v_q, init_v_d;
    logic        inv_v14_q, inv_v14_d;
    logic        g_start_q, g_start_d;
    logic        fin_xor_q, fin_xor_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        g_idx_d = g_idx_q;
        flag_d  = flag_q;

        unique case (state_q)
            CtrlIdle: begin
                if (start) begin
                    state_d = CtrlInit;
                    flag_d  = final_block;
                    round_d = '0;
                    g_idx_d = '0;
                end
            end
            CtrlInit:  state_d = CtrlIssue;
            CtrlIssue: state_d = CtrlWait;
            CtrlWait: begin
                if (g_done) begin
                    if (g_idx_q == LastG) begin
                        if (round_q == LastRound) begin
                            state_d = CtrlFinal;
                        end else begin
                            state_d = CtrlIssue;
                            round_d = round_q + 4'd1;
                            g_idx_d = '0;
                        end
                    end else begin
                        state_d = CtrlIssue;
                        g_idx_d = g_idx_q + 3'd1;
                    end
                end
            end
            CtrlFinal: state_d = CtrlDone;
            CtrlDone: begin
                state_d = CtrlIdle;
                round_d = '0;
                g_idx_d = '0;
            end
            default: begin
                state_d = CtrlIdle;
                round_d = '0;
                g_idx_d = '0;
            end
        endcase

        // Pulses are decoded from the next state so they line up with the state register.
        busy_d    = (state_d != CtrlIdle);
        init_v_d  = (state_d == CtrlInit);
        inv_v14_d = init_v_d & flag_d;
        g_start_d = (state_d == CtrlIssue);
        fin_xor_d = (state_d == CtrlFinal);
        done_d    = (state_d == CtrlDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CtrlIdle;
            round_q   <= '0;
            g_idx_q   <= '0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            init_v_q  <= 1'b0;
            inv_v14_q <= 1'b0;
            g_start_q <= 1'b0;
            fin_xor_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            g_idx_q   <= g_idx_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
            init_v_q  <= init_v_d;
            inv_v14_q <= inv_v14_d;
            g_start_q <= g_start_d;
            fin_xor_q <= fin_xor_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign init_v      = init_v_q;
    assign inv_v14     = inv_v14_q;
    assign g_start     = g_start_q;
    assign round       = round_q;
    assign g_idx       = g_idx_q;
    assign fin_xor     = fin_xor_q;
    assign done        = done_q;
    assign sigma_col_x = sigma_col(g_idx_q, 1'b0);
    // Gated so the column index reads 0 while idle/reset, like every other output.
    assign sigma_col_y = busy_q ? sigma_col(g_idx_q, 1'b1) : 4'd0;

endmodule

// File: tb/tb_blake2b_round_ctrl.sv
// Scoreboard bench for blake2b_round_ctrl: stimulus queues expected pulses, a negedge
// monitor pops and compares them as the DUT emits them.
module tb_blake2b_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       final_block = 1'b0;
    logic       g_done = 1'b0;
    logic       busy, init_v, inv_v14, g_start, fin_xor, done;
    logic [3:0] round, sigma_col_x, sigma_col_y;
    logic [2:0] g_idx;

    logic       start2 = 1'b0;
    logic       busy2, init_v2, inv_v14_2, g_start2, fin_xor2, done2;
    logic [3:0] round2, col_x2, col_y2;
    logic [2:0] g_idx2;

    blake2b_round_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .final_block(final_block), .busy(busy),
        .init_v(init_v), .inv_v14(inv_v14), .g_start(g_start), .g_done(g_done),
        .round(round), .g_idx(g_idx), .sigma_col_x(sigma_col_x), .sigma_col_y(sigma_col_y),
        .fin_xor(fin_xor), .done(done)
    );

    blake2b_round_ctrl #(.ROUNDS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .final_block(1'b0), .busy(busy2),
        .init_v(init_v2), .inv_v14(inv_v14_2), .g_start(g_start2), .g_done(1'b1),
        .round(round2), .g_idx(g_idx2), .sigma_col_x(col_x2), .sigma_col_y(col_y2),
        .fin_xor(fin_xor2), .done(done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // kind: 0 init_v, 1 g_start, 2 fin_xor, 3 done
    typedef struct {
        int kind;
        int cyc;
        int rnd;
        int gi;
        int cx;
        int cy;
        int inv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_kind;
    int   dly[96];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int k, input int inv);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.rnd  = k / 8;
        e.gi   = k % 8;
        e.cx   = 2 * (k % 8);
        e.cy   = 2 * (k % 8) + 1;
        e.inv  = inv;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (init_v || g_start || fin_xor || done)) begin
            mon_kind = init_v ? 0 : g_start ? 1 : fin_xor ? 2 : 3;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none",
                         mon_kind, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", mon_kind, mon_e.kind);
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("busy_in_pulse", int'(busy), 1);
                if (mon_e.kind == 1) begin
                    chk("round", int'(round), mon_e.rnd);
                    chk("g_idx", int'(g_idx), mon_e.gi);
                    chk("sigma_col_x", int'(sigma_col_x), mon_e.cx);
                    chk("sigma_col_y", int'(sigma_col_y), mon_e.cy);
                end
                if (mon_e.kind == 0) chk("inv_v14", int'(inv_v14), mon_e.inv);
            end
        end
        if (!rst && !init_v && inv_v14) begin
            n_cmp++;
            n_err++;
            $display("FAIL inv_v14_stray: got 1 outside init_v, expected 0 (cycle %0d)", cyc);
        end
    end

    // Called just after a posedge; that cycle is the start-accept cycle.
    task automatic compress(input logic fb, input bit var_lat, input bit hold);
        int t;
        int c;
        int b;
        t           = cyc;
        start       = 1'b1;
        final_block = fb;
        push(0, t + 1, 0, int'(fb));
        c = t + 2;
        for (int k = 0; k < 96; k++) begin
            push(1, c, k, 0);
            c += 2 + (var_lat ? dly[k] : 0);
        end
        push(2, c, 0, 0);
        push(3, c + 1, 0, 0);
        g_done = !var_lat;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        final_block = ~fb;
        if (var_lat) begin
            for (int k = 0; k < 96; k++) begin
                b = 0;
                while (!g_start && b < 40) begin
                    @(posedge clk); #1;
                    b++;
                end
                chk("g_start_seen", int'(g_start), 1);
                @(posedge clk); #1;
                for (int j = 0; j < dly[k]; j++) begin
                    @(posedge clk); #1;
                end
                g_done = 1'b1;
                @(posedge clk); #1;
                g_done = 1'b0;
            end
        end
        b = 0;
        while (!done && b < 400) begin
            @(posedge clk); #1;
            b++;
        end
        chk("done_seen", int'(done), 1);
        @(posedge clk); #1;
        g_done = 1'b0;
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        int t;
        int cnt;
        int maxr;
        int fc;
        int dc;
        for (int k = 0; k < 96; k++) dly[k] = (k * 5 + 2) % 6;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_init_v", int'(init_v), 0);
        chk("rst_inv_v14", int'(inv_v14), 0);
        chk("rst_g_start", int'(g_start), 0);
        chk("rst_round", int'(round), 0);
        chk("rst_g_idx", int'(g_idx), 0);
        chk("rst_col_x", int'(sigma_col_x), 0);
        chk("rst_col_y", int'(sigma_col_y), 0);
        chk("rst_fin_xor", int'(fin_xor), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);

        compress(1'b1, 1'b0, 1'b0);
        compress(1'b0, 1'b0, 1'b0);
        compress(1'b1, 1'b1, 1'b0);
        // start held: second compression is accepted in the IDLE cycle after done
        compress(1'b0, 1'b0, 1'b1);
        compress(1'b1, 1'b0, 1'b0);

        // Reset mid-compression while waiting at round 5, step 3 (step 43).
        t           = cyc;
        start       = 1'b1;
        final_block = 1'b0;
        g_done      = 1'b1;
        push(0, t + 1, 0, 0);
        for (int k = 0; k <= 43; k++) push(1, t + 2 + 2 * k, k, 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t + 89) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_round", int'(round), 5);
        chk("pre_rst_g_idx", int'(g_idx), 3);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_round", int'(round), 0);
        chk("mid_rst_g_idx", int'(g_idx), 0);
        chk("mid_rst_g_start", int'(g_start), 0);
        chk("mid_rst_col_x", int'(sigma_col_x), 0);
        chk("mid_rst_col_y", int'(sigma_col_y), 0);
        chk("mid_rst_fin_xor", int'(fin_xor), 0);
        chk("mid_rst_done", int'(done), 0);
        rst    = 1'b0;
        g_done = 1'b0;
        chk("sb_drained_at_rst", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        compress(1'b0, 1'b0, 1'b0);

        // ROUNDS=2 instance, g_done tied high.
        t      = cyc;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cnt    = 0;
        maxr   = 0;
        fc     = 0;
        dc     = -1;
        for (int i = 0; i < 60; i++) begin
            if (g_start2) cnt++;
            if (int'(round2) > maxr) maxr = int'(round2);
            if (fin_xor2) fc++;
            if (done2 && dc < 0) dc = cyc;
            @(posedge clk); #1;
        end
        chk("r2_g_start_count", cnt, 16);
        chk("r2_done_cycle", dc - t, 35);
        chk("r2_max_round", maxr, 1);
        chk("r2_fin_xor_count", fc, 1);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
